// File: rtl/alu_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_scheduler_pkg                                      |
// | Description : Shared widths, function codes and FSM encoding.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package alu_scheduler_pkg;

    localparam int RESULT_W  = 8;
    localparam int OPND_W    = 4;
    localparam int FUNC_W    = 3;
    localparam int MUL_STEPS = 4;

    localparam logic [FUNC_W-1:0] FN_SUM5  = 3'b000;
    localparam logic [FUNC_W-1:0] FN_ADD8  = 3'b001;
    localparam logic [FUNC_W-1:0] FN_SEXTB = 3'b010;
    localparam logic [FUNC_W-1:0] FN_ORR   = 3'b011;
    localparam logic [FUNC_W-1:0] FN_ANDR  = 3'b100;
    localparam logic [FUNC_W-1:0] FN_CAT   = 3'b101;
    localparam logic [FUNC_W-1:0] FN_MUL   = 3'b110;
    localparam logic [FUNC_W-1:0] FN_ZERO  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_scheduler_if                                       |
// | Description : Requester/result bundle between two clients and the    |
// |               shared ALU scheduler.                                  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface alu_scheduler_if;
    import alu_scheduler_pkg::*;

    logic [1:0]          Req;
    logic [OPND_W-1:0]   A0;
    logic [OPND_W-1:0]   B0;
    logic [FUNC_W-1:0]   Func0;
    logic [OPND_W-1:0]   A1;
    logic [OPND_W-1:0]   B1;
    logic [FUNC_W-1:0]   Func1;
    logic [1:0]          Grant;
    logic                Busy;
    logic                Done;
    logic                DoneId;
    logic [RESULT_W-1:0] ALUout;

    modport master (
        output Req, A0, B0, Func0, A1, B1, Func1,
        input  Grant, Busy, Done, DoneId, ALUout
    );

    modport slave (
        input  Req, A0, B0, Func0, A1, B1, Func1,
        output Grant, Busy, Done, DoneId, ALUout
    );

endinterface
`default_nettype wire

// File: rtl/part2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : part2                                                  |
// | Description : 4-bit ripple-carry adder built from full-adder cells.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module part2
    import alu_scheduler_pkg::*;
(
    input  wire logic [OPND_W-1:0] i_a,
    input  wire logic [OPND_W-1:0] i_b,
    input  wire logic              i_cin,
    output logic      [OPND_W-1:0] o_sum,
    output logic                   o_cout
);

    logic [OPND_W:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar gi = 0; gi < OPND_W; gi++) begin : g_bit
        assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_carry[OPND_W];

endmodule
`default_nettype wire

// File: rtl/part3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : part3                                                  |
// | Description : 4-bit operand ALU producing an 8-bit result.           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module part3
    import alu_scheduler_pkg::*;
(
    input  wire logic [OPND_W-1:0]   i_a,
    input  wire logic [OPND_W-1:0]   i_b,
    input  wire logic [FUNC_W-1:0]   i_func,
    output logic      [RESULT_W-1:0] o_result
);

    logic [OPND_W-1:0] w_sum;
    logic              w_cout;

    part2 u_add (
        .i_a    (i_a),
        .i_b    (i_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Multiply is sequenced by the scheduler, so it yields zero here like 111.
    always_comb begin
        o_result = '0;
        case (i_func)
            FN_SUM5:  o_result = {{(RESULT_W-OPND_W-1){1'b0}}, w_cout, w_sum};
            FN_ADD8:  o_result = {{(RESULT_W-OPND_W){1'b0}}, i_a} + {{(RESULT_W-OPND_W){1'b0}}, i_b};
            FN_SEXTB: o_result = {{(RESULT_W-OPND_W){i_b[OPND_W-1]}}, i_b};
            FN_ORR:   o_result = {{(RESULT_W-1){1'b0}}, |(i_a | i_b)};
            FN_ANDR:  o_result = {{(RESULT_W-1){1'b0}}, |(i_a & i_b)};
            FN_CAT:   o_result = {i_a, i_b};
            FN_MUL:   o_result = '0;
            FN_ZERO:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_scheduler                                          |
// | Description : Round-robin scheduler sharing one ALU and a shift-add  |
// |               multiplier between two requesters.                     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module alu_scheduler
    import alu_scheduler_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    alu_scheduler_if.slave bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_ptr;
    logic [OPND_W-1:0]   r_a;
    logic [OPND_W-1:0]   r_b;
    logic [FUNC_W-1:0]   r_func;
    logic                r_owner;
    logic [OPND_W-1:0]   r_hi;
    logic [OPND_W-1:0]   r_lo;
    logic [1:0]          r_step;
    logic [1:0]          r_grant;
    logic                r_done;
    logic                r_done_id;
    logic [RESULT_W-1:0] r_alu_out;

    logic                w_any_req;
    logic                w_winner;
    logic [OPND_W-1:0]   w_win_a;
    logic [OPND_W-1:0]   w_win_b;
    logic [FUNC_W-1:0]   w_win_func;
    logic                w_capture;
    logic                w_finish;
    logic [RESULT_W-1:0] w_alu_result;
    logic [RESULT_W-1:0] w_result;
    logic [OPND_W-1:0]   w_add_sum;
    logic                w_add_cout;
    logic                w_step_c;
    logic [OPND_W-1:0]   w_step_hi;
    logic [OPND_W-1:0]   w_hi_next;
    logic [OPND_W-1:0]   w_lo_next;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_any_req  = |bus.Req;
    assign w_winner   = (bus.Req == 2'b11) ? r_ptr : bus.Req[1];
    assign w_win_a    = w_winner ? bus.A1    : bus.A0;
    assign w_win_b    = w_winner ? bus.B1    : bus.B0;
    assign w_win_func = w_winner ? bus.Func1 : bus.Func0;

    part3 u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_func   (r_func),
        .o_result (w_alu_result)
    );

    part2 u_mul_add (
        .i_a    (r_hi),
        .i_b    (r_a),
        .i_cin  (1'b0),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // One shift-add step: conditionally add A into Hi, then shift {c,Hi,Lo} right.
    assign w_step_c  = r_lo[0] & w_add_cout;
    assign w_step_hi = r_lo[0] ? w_add_sum : r_hi;
    assign w_hi_next = {w_step_c, w_step_hi[OPND_W-1:1]};
    assign w_lo_next = {w_step_hi[0], r_lo[OPND_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        w_result     = w_alu_result;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_capture    = 1'b1;
                    w_next_state = (w_win_func == FN_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_finish     = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_MUL: begin
                w_result = {w_hi_next, w_lo_next};
                if (r_step == 2'(MUL_STEPS - 1)) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_func    <= '0;
            r_owner   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_step    <= '0;
            r_grant   <= '0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_alu_out <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            if (w_capture) begin
                r_a     <= w_win_a;
                r_b     <= w_win_b;
                r_func  <= w_win_func;
                r_owner <= w_winner;
                r_hi    <= '0;
                r_lo    <= w_win_b;
                r_step  <= '0;
                r_grant <= w_winner ? 2'b10 : 2'b01;
                r_ptr   <= ~w_winner;
            end
            if (r_state == ST_MUL) begin
                r_hi   <= w_hi_next;
                r_lo   <= w_lo_next;
                r_step <= r_step + 2'd1;
            end
            if (w_finish) begin
                r_alu_out <= w_result;
                r_done    <= 1'b1;
                r_done_id <= r_owner;
            end
        end
    end

    assign bus.Grant  = r_grant;
    assign bus.Busy   = (r_state != ST_IDLE);
    assign bus.Done   = r_done;
    assign bus.DoneId = r_done_id;
    assign bus.ALUout = r_alu_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_scheduler                                       |
// | Description : Self-checking bench for alu_scheduler.                 |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_alu_scheduler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_scheduler_if bus ();

    alu_scheduler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0, 3'd1: return 8'(ia + ib);
            3'd2:       return 8'((ib >= 8) ? ib - 16 : ib);
            3'd3:       return ((ia != 0) || (ib != 0)) ? 8'd1 : 8'd0;
            3'd4:       return ((a & b) != 4'd0) ? 8'd1 : 8'd0;
            3'd5:       return 8'(ia * 16 + ib);
            3'd6:       return 8'(ia * ib);
            default:    return 8'd0;
        endcase
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.Req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request, scrambles all operands after Grant, waits for Done.
    task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [2:0] f,
                         output logic [7:0] res, output logic id, output int lat,
                         output int busy_cnt, output bit to);
        int n;
        to = 1'b0; res = '0; id = 1'b0; lat = 0; busy_cnt = 0; n = 0;
        @(negedge clk);
        if (idx == 0) begin bus.A0 = a; bus.B0 = b; bus.Func0 = f; end
        else          begin bus.A1 = a; bus.B1 = b; bus.Func1 = f; end
        bus.Req[idx] = 1'b1;
        do begin @(negedge clk); n++; end while (bus.Grant[idx] !== 1'b1 && n < 20);
        bus.Req[idx] = 1'b0;
        if (bus.Grant[idx] !== 1'b1) begin to = 1'b1; return; end
        busy_cnt = (bus.Busy === 1'b1) ? 1 : 0;
        bus.A0 = 4'($urandom); bus.B0 = 4'($urandom); bus.Func0 = 3'($urandom);
        bus.A1 = 4'($urandom); bus.B1 = 4'($urandom); bus.Func1 = 3'($urandom);
        do begin
            @(negedge clk);
            lat++;
            if (bus.Done !== 1'b1 && bus.Busy === 1'b1) busy_cnt++;
        end while (bus.Done !== 1'b1 && lat < 20);
        if (bus.Done !== 1'b1) begin to = 1'b1; return; end
        res = bus.ALUout;
        id  = bus.DoneId;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Req = 2'b11;
        bus.A0 = 4'hF; bus.B0 = 4'h1; bus.Func0 = 3'b000;
        bus.A1 = 4'h3; bus.B1 = 4'h5; bus.Func1 = 3'b101;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.Grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", bus.Grant); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        n_checks++; if (bus.DoneId !== 1'b0) begin n_fail++; $display("FAIL reset_doneid: got %b expected 0", bus.DoneId); end
        n_checks++; if (bus.ALUout !== 8'h00) begin n_fail++; $display("FAIL reset_aluout: got %h expected 00", bus.ALUout); end
        bus.Req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sum5();
        logic [7:0] res; logic id; int lat; int bc; bit to;
        do_op(0, 4'hF, 4'h1, 3'b000, res, id, lat, bc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL sum5_timeout: got timeout expected Done"); end
        n_checks++; if (res !== 8'h10) begin n_fail++; $display("FAIL sum5_result: got %h expected 10", res); end
        n_checks++; if (id !== 1'b0) begin n_fail++; $display("FAIL sum5_doneid: got %b expected 0", id); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sum5_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_cat_sext();
        logic [7:0] res; logic id; int lat; int bc; bit to;
        do_op(1, 4'h3, 4'h5, 3'b101, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'h35) begin n_fail++; $display("FAIL cat_result: got %h (timeout %0d) expected 35", res, to); end
        n_checks++; if (id !== 1'b1) begin n_fail++; $display("FAIL cat_doneid: got %b expected 1", id); end
        do_op(1, 4'h0, 4'h8, 3'b010, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'hF8) begin n_fail++; $display("FAIL sext_result: got %h (timeout %0d) expected f8", res, to); end
    endtask

    task automatic test_mul();
        logic [7:0] res; logic id; int lat; int bc; bit to;
        do_op(0, 4'hF, 4'hF, 3'b110, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'hE1) begin n_fail++; $display("FAIL mul_ff_result: got %h (timeout %0d) expected e1", res, to); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL mul_latency: got %0d expected 4", lat); end
        n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 4", bc); end
        do_op(0, 4'h0, 4'hF, 3'b110, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'h00) begin n_fail++; $display("FAIL mul_zero_result: got %h (timeout %0d) expected 00", res, to); end
    endtask

    task automatic test_or_reduce();
        logic [7:0] res; logic id; int lat; int bc; bit to;
        do_op(0, 4'h0, 4'h0, 3'b011, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'h00) begin n_fail++; $display("FAIL orr_zero: got %h (timeout %0d) expected 00", res, to); end
        do_op(0, 4'h0, 4'h2, 3'b011, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'h01) begin n_fail++; $display("FAIL orr_one: got %h (timeout %0d) expected 01", res, to); end
        do_op(0, 4'hC, 4'h3, 3'b100, res, id, lat, bc, to);
        n_checks++; if (to || res !== 8'h00) begin n_fail++; $display("FAIL andr_zero: got %h (timeout %0d) expected 00", res, to); end
    endtask

    task automatic test_round_robin();
        logic m_ptr;
        logic exp_w;
        int   n;
        reset_dut();
        m_ptr = 1'b0;
        bus.Func0 = 3'b001; bus.Func1 = 3'b001;
        @(negedge clk);
        bus.Req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_w = m_ptr;
            m_ptr = ~exp_w;
            n = 0;
            do begin @(negedge clk); n++; end while (bus.Grant === 2'b00 && n < 10);
            n_checks++;
            if (bus.Grant !== (exp_w ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b expected %b", g, bus.Grant, exp_w ? 2'b10 : 2'b01);
            end
            bus.Req[exp_w] = 1'b0;
            @(negedge clk);
            bus.Req[exp_w] = 1'b1;
        end
        bus.Req = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] res; logic id; int lat; int bc; bit to;
        int  n;
        bit  saw_done;
        do_op(1, 4'h3, 4'h5, 3'b101, res, id, lat, bc, to);
        @(negedge clk);
        bus.A0 = 4'hF; bus.B0 = 4'hF; bus.Func0 = 3'b110;
        bus.Req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.Grant[0] !== 1'b1 && n < 20);
        bus.Req[0] = 1'b0;
        n_checks++; if (bus.Grant[0] !== 1'b1) begin n_fail++; $display("FAIL abort_grant: got %b expected 01", bus.Grant); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.Busy); end
        n_checks++; if (bus.ALUout !== 8'h00) begin n_fail++; $display("FAIL abort_aluout: got %h expected 00", bus.ALUout); end
        rst = 1'b0;
        saw_done = (bus.Done === 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got Done pulse expected none"); end
        bus.Func0 = 3'b001; bus.Func1 = 3'b001;
        bus.Req = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.Grant === 2'b00 && n < 10);
        bus.Req = 2'b00;
        n_checks++; if (bus.Grant !== 2'b01) begin n_fail++; $display("FAIL abort_next_grant: got %b expected 01", bus.Grant); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int q[$];
        reset_dut();
        bus.A0 = 4'h2; bus.B0 = 4'h3; bus.Func0 = 3'b001;
        @(negedge clk);
        bus.Req = 2'b01;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.Grant[0] === 1'b1) q.push_back(c);
        end
        bus.Req = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() < 3) begin n_fail++; $display("FAIL b2b_exec_count: got %0d grants expected >= 3", q.size()); end
        else begin
            n_checks++; if (q[1] - q[0] !== 2) begin n_fail++; $display("FAIL b2b_exec_gap: got %0d expected 2", q[1] - q[0]); end
            n_checks++; if (q[2] - q[1] !== 2) begin n_fail++; $display("FAIL b2b_exec_gap2: got %0d expected 2", q[2] - q[1]); end
        end
        n_checks++; if (bus.ALUout !== model(4'h2, 4'h3, 3'b001)) begin n_fail++; $display("FAIL b2b_exec_result: got %h expected 05", bus.ALUout); end
        q.delete();
        bus.A0 = 4'h3; bus.B0 = 4'h7; bus.Func0 = 3'b110;
        bus.Req = 2'b01;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.Grant[0] === 1'b1) q.push_back(c);
        end
        bus.Req = 2'b00;
        repeat (8) @(negedge clk);
        n_checks++;
        if (q.size() < 3) begin n_fail++; $display("FAIL b2b_mul_count: got %0d grants expected >= 3", q.size()); end
        else begin
            n_checks++; if (q[1] - q[0] !== 5) begin n_fail++; $display("FAIL b2b_mul_gap: got %0d expected 5", q[1] - q[0]); end
        end
        n_checks++; if (bus.ALUout !== 8'h15) begin n_fail++; $display("FAIL b2b_mul_result: got %h expected 15", bus.ALUout); end
    endtask

    task automatic test_random();
        logic [7:0] res; logic id; int lat; int bc; bit to;
        int idx; logic [3:0] a; logic [3:0] b; logic [2:0] f;
        for (int i = 0; i < 24; i++) begin
            idx = int'($urandom_range(0, 1));
            a = 4'($urandom); b = 4'($urandom);
            f = (i % 4 == 0) ? 3'b110 : 3'($urandom);
            do_op(idx, a, b, f, res, id, lat, bc, to);
            n_checks++;
            if (to || res !== model(a, b, f)) begin
                n_fail++;
                $display("FAIL rand_result_%0d: got %h (timeout %0d) expected %h for a=%h b=%h f=%0d", i, res, to, model(a, b, f), a, b, f);
            end
            n_checks++; if (id !== idx[0]) begin n_fail++; $display("FAIL rand_doneid_%0d: got %b expected %0d", i, id, idx); end
            n_checks++; if (lat !== ((f == 3'b110) ? 4 : 1)) begin n_fail++; $display("FAIL rand_latency_%0d: got %0d expected %0d", i, lat, (f == 3'b110) ? 4 : 1); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.Req  = 2'b00;
        bus.A0 = '0; bus.B0 = '0; bus.Func0 = '0;
        bus.A1 = '0; bus.B1 = '0; bus.Func1 = '0;
        test_reset();
        test_sum5();
        test_cat_sext();
        test_mul();
        test_or_reduce();
        test_round_robin();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Clock  in  1  rising-edge system clock; all state changes on this edge.
REQ-002 Reset  in  1  synchronous, active-high reset; one clock, reset synchronous active-high.
REQ-003 Req  in  2  per-requester request; Req[i] held high until Grant[i] seen.
REQ-004 A0, B0  in  4 each  requester-0 operands.
REQ-005 Func0  in  3  requester-0 function code.
REQ-006 A1, B1  in  4 each  requester-1 operands.
REQ-007 Func1  in  3  requester-1 function code.
REQ-008 Grant  out  2  one-hot, one-cycle pulse: operands of requester i captured.
REQ-009 Busy  out  1  high while an operation is in flight (state != IDLE).
REQ-010 Done  out  1  one-cycle pulse: ALUout valid for DoneId.
REQ-011 DoneId  out  1  index of requester owning the current result.
REQ-012 ALUout  out  8  registered result; holds its value until the next Done.

Function
REQ-013 States SHALL be IDLE, EXEC, MUL; encoding 2 bits.
REQ-014 In IDLE, if any Req bit is high at edge k, the block SHALL:
  - capture A/B/Func of the winner;
  - assert Grant[winner] for the cycle after edge k;
  - go to EXEC (Func != 110) or MUL (Func == 110).
REQ-015 Arbitration SHALL be round-robin:
  - single requester wins outright;
  - on a tie, the requester indicated by pointer Ptr wins;
  - Ptr SHALL become ~winner after every grant.
REQ-016 Req SHALL be ignored while Busy; no queuing, no loss (requester holds Req).
REQ-017 Func 000..101 in EXEC SHALL use standard ALU semantics:
  - 000 = {3'b0, 5-bit ripple sum with carry};
  - 001 = A+B (8-bit result);
  - 010 = sign-extend B;
  - 011 = |(A|B);
  - 100 = |(A&B);
  - 101 = {A,B}.
  The result SHALL be registered at edge k+1, Done SHALL pulse in the following cycle, and the block SHALL return to IDLE.
REQ-018 Func 111 SHALL follow the same EXEC path with result 8'h00.
REQ-019 Func 110 SHALL be an unsigned 4x4 multiply over 4 MUL steps at edges k+1..k+4:
  - Hi=0, Lo=B initially;
  - each step: if Lo[0], {c,Hi}=Hi+A, else c=0; then {c,Hi,Lo} shifted right by 1.
  ALUout SHALL be {Hi,Lo} at edge k+4, with Done in the following cycle.
REQ-020 Minimum spacing SHALL be one grant per 2 cycles for single-cycle ops and one grant per 5 cycles for multiply; a new capture is allowed on the edge after Done is asserted.
REQ-021 Grant and Done SHALL never both be high in the same cycle for the same op; Grant and Done of different ops may coincide.
REQ-022 Operands SHALL be taken from capture registers only; input changes after Grant SHALL have no effect.

Reset
REQ-023 Reset SHALL force the following:
  - state = IDLE, Ptr = 0;
  - Grant = 0, Busy = 0, Done = 0, DoneId = 0, ALUout = 8'h00;
  - capture and Hi/Lo registers = 0.
REQ-024 Reset mid-operation SHALL abort the operation with no Done pulse; Reset SHALL override a simultaneous Req.

Structure
REQ-025 A shared package SHALL hold the function-code constants (000..111), the state encoding and the RESULT_W=8 / OPND_W=4 constants.
REQ-026 Single-cycle ops SHALL use one instance of the existing 4-bit ALU, part3, fed from the capture registers.
REQ-027 Multiply steps SHALL use one instance of the existing 4-bit ripple adder, part2 (c_in=0), with no behavioural "*".

Verification
REQ-028 Req=01, Func0=000, A0=F, B0=1 -> Grant=01 for 1 cycle; one cycle later Done=1, DoneId=0, ALUout=8'h10.
REQ-029 Req=10, Func1=101, A1=3, B1=5 -> ALUout=8'h35, DoneId=1; Func1=010, B1=8 -> ALUout=8'hF8.
REQ-030 Func0=110, A0=F, B0=F -> Busy for 4 MUL cycles, Done 4 cycles after Grant, ALUout=8'hE1; A0=0 -> 8'h00.
REQ-031 After reset, Req=11 held -> grants in order 0,1,0,1; each requester drops Req after its Grant and re-raises it.
REQ-032 Reset asserted during the 2nd MUL step -> no Done, ALUout=0, Busy=0 next cycle; next Req=11 granted to requester 0.
REQ-033 Func0=011 with A0=0, B0=0 -> ALUout=8'h00; A0=0, B0=2 -> 8'h01; changes to A0 after Grant do not alter the result.
